// File: rtl/tcdm_bank_arbiter_if.sv
// Bus bundle for one TCDM bank arbiter: NB_IN requester ports plus the single bank port.
// The slave modport is the arbiter's view. The master modport is the environment's view
// (the interconnect routing stage together with the bank).
interface tcdm_bank_arbiter_if #(
    parameter int unsigned NB_IN          = 4,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_MEM_WIDTH = 11,
    parameter int unsigned BE_WIDTH       = DATA_WIDTH / 8
);
    // requester side
    logic [NB_IN-1:0]                     req_i;
    logic [NB_IN-1:0][ADDR_MEM_WIDTH-1:0] add_i;
    logic [NB_IN-1:0]                     wen_i;
    logic [NB_IN-1:0][DATA_WIDTH-1:0]     wdata_i;
    logic [NB_IN-1:0][BE_WIDTH-1:0]       be_i;
    logic [NB_IN-1:0]                     gnt_o;
    logic [NB_IN-1:0]                     r_valid_o;
    logic [DATA_WIDTH-1:0]                r_rdata_o;
    // bank side
    logic                                 req_o;
    logic [ADDR_MEM_WIDTH-1:0]            add_o;
    logic                                 wen_o;
    logic [DATA_WIDTH-1:0]                wdata_o;
    logic [BE_WIDTH-1:0]                  be_o;
    logic                                 gnt_i;
    logic [DATA_WIDTH-1:0]                rdata_i;

    modport slave (
        input  req_i, add_i, wen_i, wdata_i, be_i, gnt_i, rdata_i,
        output gnt_o, r_valid_o, r_rdata_o, req_o, add_o, wen_o, wdata_o, be_o
    );

    modport master (
        output req_i, add_i, wen_i, wdata_i, be_i, gnt_i, rdata_i,
        input  gnt_o, r_valid_o, r_rdata_o, req_o, add_o, wen_o, wdata_o, be_o
    );
endinterface

// File: rtl/tcdm_bank_arbiter.sv
// Per-bank arbiter: picks one of NB_IN requesters per cycle (round-robin / fixed-priority) for one SRAM bank port.
// Latency: grant is combinational in the request cycle; the response (r_valid_o/r_rdata_o) comes exactly 1 cycle later.
// Backpressure: gnt_i=0 stalls, with no grant and no pointer/response update. Optional aging (macro TCDM_ARB_AGING_EN) prevents starvation.
module tcdm_bank_arbiter #(
    parameter int unsigned NB_IN          = 4,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_MEM_WIDTH = 11,
    parameter int unsigned BE_WIDTH       = DATA_WIDTH / 8,
    parameter int unsigned STARVE_LIMIT   = 15
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [1:0]           arb_policy_i,
    tcdm_bank_arbiter_if.slave   bus
);
    localparam int unsigned PTR_W = $clog2(NB_IN);

    typedef enum logic [1:0] {
        POL_RR     = 2'b00,
        POL_FIX_LO = 2'b01,
        POL_FIX_HI = 2'b10,
        POL_RR_ALT = 2'b11
    } pol_e;

    pol_e             r_pol_q;
    logic [PTR_W-1:0] r_rr_ptr_q;
    logic [NB_IN-1:0] r_resp_q;

    logic [NB_IN-1:0] w_starved;
    logic             w_win_vld;
    logic [PTR_W-1:0] w_win;
    logic             w_accept;
    logic [NB_IN-1:0] w_gnt;
    int               w_rr_idx;

`ifdef TCDM_ARB_AGING_EN
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [NB_IN-1:0][CNT_W-1:0] r_age_q;

    // Count cycles each input waits with its request up. Clear on grant or when the request drops.
    // The counters keep running while the bank stalls.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_age_q <= '0;
        end else begin
            for (int k = 0; k < NB_IN; k++) begin
                if (!bus.req_i[k] || w_gnt[k]) begin
                    r_age_q[k] <= '0;
                end else if (r_age_q[k] != CNT_W'(STARVE_LIMIT)) begin
                    r_age_q[k] <= r_age_q[k] + 1'b1;
                end
            end
        end
    end

    // An input is starved once its counter saturates while it still requests.
    always_comb begin
        w_starved = '0;
        for (int k = 0; k < NB_IN; k++) begin
            w_starved[k] = bus.req_i[k] && (r_age_q[k] == CNT_W'(STARVE_LIMIT));
        end
    end
`else
    assign w_starved = '0;

    // STARVE_LIMIT only sizes the aging counters. It is kept as a parameter so both builds share one port list.
    if (STARVE_LIMIT < 1) begin : g_starve_limit_unused
    end
`endif

    // Winner selection. Starved inputs override the policy (lowest index first).
    // Otherwise: fixed-low, fixed-high, or round-robin from r_rr_ptr_q.
    // The descending loops let the preferred candidate be written last.
    always_comb begin
        w_win_vld = 1'b0;
        w_win     = '0;
        w_rr_idx  = 0;
        if (|w_starved) begin
            for (int i = NB_IN - 1; i >= 0; i--) begin
                if (w_starved[i]) begin
                    w_win_vld = 1'b1;
                    w_win     = PTR_W'(i);
                end
            end
        end else begin
            case (r_pol_q)
                POL_FIX_LO: begin
                    for (int i = NB_IN - 1; i >= 0; i--) begin
                        if (bus.req_i[i]) begin
                            w_win_vld = 1'b1;
                            w_win     = PTR_W'(i);
                        end
                    end
                end
                POL_FIX_HI: begin
                    for (int i = 0; i < NB_IN; i++) begin
                        if (bus.req_i[i]) begin
                            w_win_vld = 1'b1;
                            w_win     = PTR_W'(i);
                        end
                    end
                end
                default: begin
                    for (int i = NB_IN - 1; i >= 0; i--) begin
                        w_rr_idx = int'(r_rr_ptr_q) + i;
                        if (w_rr_idx >= int'(NB_IN)) w_rr_idx = w_rr_idx - int'(NB_IN);
                        if (bus.req_i[w_rr_idx]) begin
                            w_win_vld = 1'b1;
                            w_win     = PTR_W'(w_rr_idx);
                        end
                    end
                end
            endcase
        end
    end

    assign w_accept = w_win_vld & bus.gnt_i;

    // Grant is one-hot on the winner, and only when the bank accepts this cycle.
    always_comb begin
        w_gnt = '0;
        if (w_accept) w_gnt[w_win] = 1'b1;
    end

    // Bank-side request: mux the winner's fields. It is idle (all zero, wen=1 i.e. read) when nothing is pending.
    always_comb begin
        bus.req_o   = |bus.req_i;
        bus.add_o   = '0;
        bus.wen_o   = 1'b1;
        bus.wdata_o = '0;
        bus.be_o    = '0;
        if (w_win_vld) begin
            bus.add_o   = bus.add_i[w_win];
            bus.wen_o   = bus.wen_i[w_win];
            bus.wdata_o = bus.wdata_i[w_win];
            bus.be_o    = bus.be_i[w_win];
        end
    end

    assign bus.gnt_o     = w_gnt;
    assign bus.r_valid_o = r_resp_q;
    assign bus.r_rdata_o = (|r_resp_q) ? bus.rdata_i : '0;

    // Policy is registered every cycle. The pointer advances past the winner only on an accepted grant.
    // The response tracks the grant one cycle later (reads and writes alike).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pol_q    <= POL_RR;
            r_rr_ptr_q <= '0;
            r_resp_q   <= '0;
        end else begin
            r_pol_q  <= pol_e'(arb_policy_i);
            r_resp_q <= w_gnt;
            if (w_accept) begin
                r_rr_ptr_q <= (w_win == PTR_W'(NB_IN - 1)) ? '0 : w_win + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_tcdm_bank_arbiter.sv
// Testbench for tcdm_bank_arbiter: a rule-level arbitration model plus a bank memory model.
// Drives inputs 1ns after posedge and samples outputs on the negedge.
// Tests both builds; expectations depend on whether TCDM_ARB_AGING_EN is defined.
`timescale 1ns/1ps
module tb_tcdm_bank_arbiter;
    localparam int NB  = 4;
    localparam int DW  = 32;
    localparam int AW  = 11;
    localparam int BW  = DW / 8;
    localparam int LIM = 15;
    localparam int BUSW = AW + 1 + DW + BW;
`ifdef TCDM_ARB_AGING_EN
    localparam bit AGING = 1'b1;
`else
    localparam bit AGING = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [1:0] policy;

    tcdm_bank_arbiter_if #(.NB_IN(NB), .DATA_WIDTH(DW), .ADDR_MEM_WIDTH(AW), .BE_WIDTH(BW)) bus ();

    tcdm_bank_arbiter #(
        .NB_IN(NB), .DATA_WIDTH(DW), .ADDR_MEM_WIDTH(AW), .BE_WIDTH(BW), .STARVE_LIMIT(LIM)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .arb_policy_i(policy),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    // reference model state
    int          m_ptr;
    int          m_pol;
    int          m_resp;
    int          m_age [NB];
    logic [DW-1:0] mem [0:(1<<AW)-1];

    task automatic model_reset();
        m_ptr  = 0;
        m_pol  = 0;
        m_resp = -1;
        for (int k = 0; k < NB; k++) m_age[k] = 0;
    endtask

    // Who should win now, from the arbitration rules applied to current inputs.
    function automatic int model_winner();
        if (AGING) begin
            for (int k = 0; k < NB; k++)
                if (bus.req_i[k] && m_age[k] == LIM) return k;
        end
        if (bus.req_i == '0) return -1;
        if (m_pol == 1) begin
            for (int k = 0; k < NB; k++) if (bus.req_i[k]) return k;
        end else if (m_pol == 2) begin
            for (int k = NB - 1; k >= 0; k--) if (bus.req_i[k]) return k;
        end else begin
            for (int i = 0; i < NB; i++) if (bus.req_i[(m_ptr + i) % NB]) return (m_ptr + i) % NB;
        end
        return -1;
    endfunction

    function automatic logic [NB-1:0] onehot(int w);
        logic [NB-1:0] v;
        v = '0;
        if (w >= 0) v[w] = 1'b1;
        return v;
    endfunction

    function automatic logic [NB-1:0] exp_gnt();
        int w;
        w = model_winner();
        return (bus.gnt_i === 1'b1) ? onehot(w) : '0;
    endfunction

    // Advance model and bank across one posedge; then drive bank read data for the next cycle.
    task automatic tick();
        int            w;
        bit            acc;
        logic [1:0]    pol_s;
        logic [DW-1:0] rd;
        logic [AW-1:0] a;
        w     = model_winner();
        acc   = (w >= 0) && (bus.gnt_i === 1'b1);
        pol_s = policy;
        @(posedge clk);
        for (int k = 0; k < NB; k++) begin
            if (!bus.req_i[k] || (acc && w == k)) m_age[k] = 0;
            else if (m_age[k] < LIM) m_age[k]++;
        end
        m_pol = int'(pol_s);
        rd    = $urandom;
        if (acc) begin
            m_ptr  = (w + 1) % NB;
            m_resp = w;
            a      = bus.add_i[w];
            if (bus.wen_i[w]) rd = mem[a];
            else
                for (int b = 0; b < BW; b++)
                    if (bus.be_i[w][b]) mem[a][8*b +: 8] = bus.wdata_i[w][8*b +: 8];
        end else begin
            m_resp = -1;
        end
        #1;
        bus.rdata_i = rd;
    endtask

    task automatic test_reset();
        logic [BUSW-1:0] act;
        rst_n = 1'b0;
        policy = 2'b00;
        bus.req_i = '0; bus.wen_i = '1; bus.be_i = '1; bus.gnt_i = 1'b1;
        for (int k = 0; k < NB; k++) begin
            bus.add_i[k]   = AW'(16 * k + 3);
            bus.wdata_i[k] = $urandom;
        end
        bus.rdata_i = 32'hA5A5_A5A5;
        model_reset();
        @(negedge clk);
        n_vec++; if (bus.r_valid_o !== '0) begin n_fail++; $display("FAIL reset_rvalid: got %b expected 0", bus.r_valid_o); end
        n_vec++; if (bus.r_rdata_o !== '0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", bus.r_rdata_o); end
        n_vec++; if (bus.gnt_o !== '0) begin n_fail++; $display("FAIL reset_gnt: got %b expected 0", bus.gnt_o); end
        n_vec++; if (bus.req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req_o: got %b expected 0", bus.req_o); end
        act = {bus.add_o, bus.wen_o, bus.wdata_o, bus.be_o};
        n_vec++; if (act !== {AW'(0), 1'b1, DW'(0), BW'(0)}) begin n_fail++; $display("FAIL reset_idle_bus: got %h expected idle", act); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_round_robin();
        int prev;
        int exp_seq [5] = '{0, 1, 2, 3, 0};
        policy = 2'b00;
        bus.add_i[0] = 11'h123;
        mem[11'h123] = 32'hDEAD_BEEF;
        bus.wen_i = '1;
        bus.req_i = '1;
        bus.gnt_i = 1'b1;
        prev = -1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c < 5) begin
                n_vec++;
                if (bus.gnt_o !== onehot(exp_seq[c])) begin n_fail++; $display("FAIL rr_gnt c%0d: got %b expected %b", c, bus.gnt_o, onehot(exp_seq[c])); end
                n_vec++;
                if (bus.add_o !== bus.add_i[exp_seq[c]]) begin n_fail++; $display("FAIL rr_add c%0d: got %h expected %h", c, bus.add_o, bus.add_i[exp_seq[c]]); end
            end
            n_vec++;
            if (bus.r_valid_o !== onehot(prev)) begin n_fail++; $display("FAIL rr_rvalid c%0d: got %b expected %b", c, bus.r_valid_o, onehot(prev)); end
            if (c == 1) begin
                n_vec++;
                if (bus.r_rdata_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rr_rdata: got %h expected deadbeef", bus.r_rdata_o); end
            end
            if (c < 5) prev = exp_seq[c];
            tick();
        end
        bus.req_i = '0;
        tick();
    endtask

    task automatic test_fixed_prio();
        policy = 2'b01;
        bus.req_i = '0;
        tick();
        bus.req_i = 4'b1010;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_vec++; if (bus.gnt_o !== 4'b0010) begin n_fail++; $display("FAIL fixlo_gnt c%0d: got %b expected 0010", c, bus.gnt_o); end
            tick();
        end
        policy = 2'b10;
        @(negedge clk);
        n_vec++; if (bus.gnt_o !== 4'b0010) begin n_fail++; $display("FAIL fixhi_change_cycle: got %b expected 0010", bus.gnt_o); end
        tick();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_vec++; if (bus.gnt_o !== 4'b1000) begin n_fail++; $display("FAIL fixhi_gnt c%0d: got %b expected 1000", c, bus.gnt_o); end
            tick();
        end
        bus.req_i = '0;
        tick();
    endtask

    task automatic test_gnt_stall();
        policy = 2'b00;
        bus.req_i = '0;
        tick();
        bus.req_i = 4'b0100;
        bus.gnt_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_vec++; if (bus.gnt_o !== '0) begin n_fail++; $display("FAIL stall_gnt c%0d: got %b expected 0000", c, bus.gnt_o); end
            n_vec++; if (bus.r_valid_o !== '0) begin n_fail++; $display("FAIL stall_rvalid c%0d: got %b expected 0000", c, bus.r_valid_o); end
            n_vec++; if (bus.req_o !== 1'b1) begin n_fail++; $display("FAIL stall_req_o c%0d: got %b expected 1", c, bus.req_o); end
            tick();
        end
        bus.gnt_i = 1'b1;
        @(negedge clk);
        n_vec++; if (bus.gnt_o !== 4'b0100) begin n_fail++; $display("FAIL stall_release_gnt: got %b expected 0100", bus.gnt_o); end
        tick();
        bus.req_i = '1;
        @(negedge clk);
        n_vec++; if (bus.r_valid_o !== 4'b0100) begin n_fail++; $display("FAIL stall_rvalid_after: got %b expected 0100", bus.r_valid_o); end
        n_vec++; if (bus.gnt_o !== 4'b1000) begin n_fail++; $display("FAIL stall_ptr_after: got %b expected 1000", bus.gnt_o); end
        tick();
        bus.req_i = '0;
        tick();
    endtask

    task automatic test_aging();
        int n3;
        int last;
        logic [NB-1:0] e;
        policy = 2'b01;
        bus.req_i = '0;
        bus.gnt_i = 1'b1;
        tick();
        tick();
        bus.req_i = 4'b1001;
        n3 = 0;
        last = -1;
        for (int c = 0; c < 48; c++) begin
            @(negedge clk);
            e = exp_gnt();
            n_vec++; if (bus.gnt_o !== e) begin n_fail++; $display("FAIL aging_gnt c%0d: got %b expected %b", c, bus.gnt_o, e); end
            if (bus.gnt_o[3] === 1'b1) begin
                if (last >= 0) begin
                    n_vec++; if (c - last != 16) begin n_fail++; $display("FAIL aging_gap: got %0d expected 16", c - last); end
                end
                last = c;
                n3++;
            end
            tick();
        end
        n_vec++;
        if (n3 != (AGING ? 3 : 0)) begin n_fail++; $display("FAIL aging_count: got %0d expected %0d", n3, AGING ? 3 : 0); end
        bus.req_i = '0;
        tick();
    endtask

    task automatic test_random();
        int              w;
        logic [NB-1:0]   e;
        logic [BUSW-1:0] eb;
        logic [BUSW-1:0] ab;
        logic [DW-1:0]   er;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 7) == 0) policy = 2'($urandom);
            bus.req_i = NB'($urandom);
            bus.gnt_i = ($urandom_range(0, 3) != 0);
            bus.wen_i = NB'($urandom);
            for (int k = 0; k < NB; k++) begin
                bus.add_i[k]   = AW'($urandom_range(0, 15));
                bus.wdata_i[k] = $urandom;
                bus.be_i[k]    = BW'($urandom);
            end
            @(negedge clk);
            w  = model_winner();
            e  = exp_gnt();
            eb = (w >= 0) ? {bus.add_i[w], bus.wen_i[w], bus.wdata_i[w], bus.be_i[w]} : {AW'(0), 1'b1, DW'(0), BW'(0)};
            ab = {bus.add_o, bus.wen_o, bus.wdata_o, bus.be_o};
            er = (m_resp >= 0) ? bus.rdata_i : '0;
            n_vec++; if (bus.gnt_o !== e) begin n_fail++; $display("FAIL rand_gnt c%0d: got %b expected %b", c, bus.gnt_o, e); end
            n_vec++; if (bus.req_o !== (|bus.req_i)) begin n_fail++; $display("FAIL rand_req_o c%0d: got %b expected %b", c, bus.req_o, |bus.req_i); end
            n_vec++; if (ab !== eb) begin n_fail++; $display("FAIL rand_bus c%0d: got %h expected %h", c, ab, eb); end
            n_vec++; if (bus.r_valid_o !== onehot(m_resp)) begin n_fail++; $display("FAIL rand_rvalid c%0d: got %b expected %b", c, bus.r_valid_o, onehot(m_resp)); end
            n_vec++; if (bus.r_rdata_o !== er) begin n_fail++; $display("FAIL rand_rdata c%0d: got %h expected %h", c, bus.r_rdata_o, er); end
            tick();
        end
        bus.req_i = '0;
        bus.gnt_i = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid();
        policy = 2'b00;
        bus.req_i = '0;
        bus.gnt_i = 1'b1;
        tick();
        bus.req_i = 4'b0010;
        @(negedge clk);
        n_vec++; if (bus.gnt_o !== 4'b0010) begin n_fail++; $display("FAIL rstmid_gnt: got %b expected 0010", bus.gnt_o); end
        tick();
        bus.req_i = '0;
        policy = 2'b10;
        #1;
        n_vec++; if (bus.r_valid_o !== 4'b0010) begin n_fail++; $display("FAIL rstmid_pre_rvalid: got %b expected 0010", bus.r_valid_o); end
        rst_n = 1'b0;
        #1;
        n_vec++; if (bus.r_valid_o !== '0) begin n_fail++; $display("FAIL rstmid_rvalid_drop: got %b expected 0000", bus.r_valid_o); end
        n_vec++; if (bus.r_rdata_o !== '0) begin n_fail++; $display("FAIL rstmid_rdata: got %h expected 0", bus.r_rdata_o); end
        model_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.req_i = 4'b1010;
        @(negedge clk);
        n_vec++; if (bus.gnt_o !== 4'b0010) begin n_fail++; $display("FAIL rstmid_first_gnt: got %b expected 0010", bus.gnt_o); end
        n_vec++; if (bus.r_valid_o !== '0) begin n_fail++; $display("FAIL rstmid_no_replay: got %b expected 0000", bus.r_valid_o); end
        tick();
        @(negedge clk);
        n_vec++; if (bus.gnt_o !== 4'b1000) begin n_fail++; $display("FAIL rstmid_pol_after: got %b expected 1000", bus.gnt_o); end
        tick();
        bus.req_i = '0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
        test_reset();
        test_round_robin();
        test_fixed_prio();
        test_gnt_stall();
        test_aging();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
